// File: rtl/reg_writeback_queue_pkg.sv
// Shared widths and entry type for the register-file writeback queue.
// DATA_W/ADDR_W/NUM_REGS must match the register file they feed.
package reg_writeback_queue_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam int unsigned CNT_W    = ADDR_W + 1;
  localparam int unsigned DEPTH    = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_queue_if.sv
// Writeback request ports, register-file write port and hazard/forwarding taps.
// slave = the queue itself, master = the producers/consumers around it.
interface reg_writeback_queue_if;
  import reg_writeback_queue_pkg::*;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;

  logic              Reg_Write;
  logic [ADDR_W-1:0] Reg_input_address;
  logic [DATA_W-1:0] Reg_input_data;

  logic [NUM_REGS-1:0] busy_mask;
  logic [ADDR_W-1:0]   fwd_addr;
  logic                fwd_hit;
  logic [DATA_W-1:0]   fwd_data;
  logic [CNT_W-1:0]    pending_count;

  modport slave (
    input  mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data, fwd_addr,
    output mem_ready, alu_ready, Reg_Write, Reg_input_address, Reg_input_data,
           busy_mask, fwd_hit, fwd_data, pending_count
  );

  modport master (
    output mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data, fwd_addr,
    input  mem_ready, alu_ready, Reg_Write, Reg_input_address, Reg_input_data,
           busy_mask, fwd_hit, fwd_data, pending_count
  );

endinterface

// File: rtl/reg_writeback_queue_wb_fifo.sv
// Circular writeback buffer with a 0/1/2-entry push and 1-entry pop per cycle.
// Entries are presented oldest-first (index 0 = head) so callers can scan by age.
module reg_writeback_queue_wb_fifo
  import reg_writeback_queue_pkg::*;
#(
  parameter int unsigned Depth = DEPTH,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [1:0]      push_cnt,
  input  wb_entry_t       wr_a,
  input  wb_entry_t       wr_b,
  input  logic            pop,
  output wb_entry_t       ord_entry [Depth],
  output logic [Depth-1:0] ord_valid,
  output logic [CntW-1:0] count
);

  wb_entry_t       mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  // wr_a always lands first; wr_b only when two entries arrive together.
  always_ff @(posedge CLK) begin
    if (push_cnt != 2'd0) mem_q[wr_ptr_q] <= wr_a;
    if (push_cnt == 2'd2) mem_q[wr_ptr_q + PtrW'(1)] <= wr_b;
  end

  // Pointer arithmetic wraps naturally because Depth is a power of two.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PtrW'(push_cnt);
      rd_ptr_q <= rd_ptr_q + PtrW'(pop);
      count_q  <= count_q + CntW'(push_cnt) - CntW'(pop);
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < Depth; k++) begin
      ord_entry[k] = mem_q[rd_ptr_q + PtrW'(k)];
      ord_valid[k] = (CntW'(k) < count_q);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/reg_writeback_queue.sv
// Merges ALU and load-unit writebacks into one in-order register-file write stream,
// and exposes pending-write hazard mask and youngest-value forwarding.
module reg_writeback_queue
  import reg_writeback_queue_pkg::*;
#(
  parameter int unsigned Depth = DEPTH
) (
  input logic                  CLK,
  input logic                  Reset,
  reg_writeback_queue_if.slave bus
);

  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [CntW-1:0]  count, free;
  wb_entry_t        ord_entry [Depth];
  logic [Depth-1:0] ord_valid;
  logic             mem_take, alu_take, pop;
  logic [1:0]       push_cnt;
  wb_entry_t        mem_ent, alu_ent, wr_a;

  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  // Readiness looks only at the registered count; a same-edge pop is not credited.
  assign free          = CntW'(Depth) - count;
  assign bus.mem_ready = (free >= CntW'(1));
  assign bus.alu_ready = bus.mem_valid ? (free >= CntW'(2)) : (free >= CntW'(1));

  assign mem_take = bus.mem_valid & bus.mem_ready;
  assign alu_take = bus.alu_valid & bus.alu_ready;
  assign push_cnt = {1'b0, mem_take} + {1'b0, alu_take};
  assign mem_ent  = '{addr: bus.mem_addr, data: bus.mem_data};
  assign alu_ent  = '{addr: bus.alu_addr, data: bus.alu_data};
  assign wr_a     = mem_take ? mem_ent : alu_ent;
  assign pop      = (count != '0);

  reg_writeback_queue_wb_fifo #(
    .Depth(Depth)
  ) u_fifo (
    .CLK      (CLK),
    .Reset    (Reset),
    .push_cnt (push_cnt),
    .wr_a     (wr_a),
    .wr_b     (alu_ent),
    .pop      (pop),
    .ord_entry(ord_entry),
    .ord_valid(ord_valid),
    .count    (count)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wr_q <= pop;
      if (pop) begin
        addr_q <= ord_entry[0].addr;
        data_q <= ord_entry[0].data;
      end
    end
  end

  // Output stage is oldest; later matches in the age-ordered scan override it.
  always_comb begin
    bus.busy_mask = '0;
    bus.fwd_hit   = 1'b0;
    bus.fwd_data  = '0;
    if (wr_q) begin
      bus.busy_mask[addr_q] = 1'b1;
      if (addr_q == bus.fwd_addr) begin
        bus.fwd_hit  = 1'b1;
        bus.fwd_data = data_q;
      end
    end
    for (int unsigned k = 0; k < Depth; k++) begin
      if (ord_valid[k]) begin
        bus.busy_mask[ord_entry[k].addr] = 1'b1;
        if (ord_entry[k].addr == bus.fwd_addr) begin
          bus.fwd_hit  = 1'b1;
          bus.fwd_data = ord_entry[k].data;
        end
      end
    end
  end

  assign bus.Reg_Write         = wr_q;
  assign bus.Reg_input_address = addr_q;
  assign bus.Reg_input_data    = data_q;
  assign bus.pending_count     = CNT_W'(count);

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue: reset, single/dual writeback, back-to-back
// streaming against an ordering model, forwarding priority and mid-flight reset.
module tb_reg_writeback_queue;
  import reg_writeback_queue_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  reg_writeback_queue_if bus ();

  reg_writeback_queue dut (
    .CLK  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mem_valid = 1'b0;
    bus.alu_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_data  = '0;
    bus.alu_addr  = '0;
    bus.alu_data  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.fwd_addr = 3'd0;
    #2;
    checks++; if (bus.Reg_Write !== 1'b0) begin errors++; $display("FAIL reset_reg_write got %b want 0", bus.Reg_Write); end
    checks++; if (bus.busy_mask !== 8'h00) begin errors++; $display("FAIL reset_busy got %h want 00", bus.busy_mask); end
    checks++; if (bus.pending_count !== 4'd0) begin errors++; $display("FAIL reset_pending got %0d want 0", bus.pending_count); end
    #13;
    rst = 1'b0;
    #1;
    checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL reset_mem_ready got %b want 1", bus.mem_ready); end
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready got %b want 1", bus.alu_ready); end
    checks++; if (bus.Reg_input_address !== 3'd0 || bus.Reg_input_data !== 16'h0) begin errors++; $display("FAIL reset_out_regs got %h/%h want 0/0", bus.Reg_input_address, bus.Reg_input_data); end
    step();
  endtask

  task automatic test_single_alu();
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 3'd1;
    bus.alu_data  = 16'h1234;
    step();
    idle_inputs();
    checks++; if (bus.busy_mask !== 8'h02) begin errors++; $display("FAIL single_busy_q got %h want 02", bus.busy_mask); end
    checks++; if (bus.Reg_Write !== 1'b0) begin errors++; $display("FAIL single_no_bypass got %b want 0", bus.Reg_Write); end
    checks++; if (bus.pending_count !== 4'd1) begin errors++; $display("FAIL single_pending got %0d want 1", bus.pending_count); end
    step();
    checks++; if (bus.Reg_Write !== 1'b1 || bus.Reg_input_address !== 3'd1 || bus.Reg_input_data !== 16'h1234) begin errors++; $display("FAIL single_write got %b %h %h want 1 1 1234", bus.Reg_Write, bus.Reg_input_address, bus.Reg_input_data); end
    checks++; if (bus.busy_mask !== 8'h02) begin errors++; $display("FAIL single_busy_out got %h want 02", bus.busy_mask); end
    step();
    checks++; if (bus.Reg_Write !== 1'b0) begin errors++; $display("FAIL single_one_write got %b want 0", bus.Reg_Write); end
    checks++; if (bus.busy_mask !== 8'h00) begin errors++; $display("FAIL single_busy_clear got %h want 00", bus.busy_mask); end
    checks++; if (bus.Reg_input_address !== 3'd1 || bus.Reg_input_data !== 16'h1234) begin errors++; $display("FAIL single_hold got %h %h want 1 1234", bus.Reg_input_address, bus.Reg_input_data); end
  endtask

  task automatic test_dual_accept();
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 3'd3;
    bus.mem_data  = 16'h5555;
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 3'd2;
    bus.alu_data  = 16'hAAAA;
    #1;
    checks++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin errors++; $display("FAIL dual_ready got %b%b want 11", bus.mem_ready, bus.alu_ready); end
    step();
    idle_inputs();
    checks++; if (bus.pending_count !== 4'd2) begin errors++; $display("FAIL dual_pending got %0d want 2", bus.pending_count); end
    checks++; if (bus.busy_mask !== 8'h0C) begin errors++; $display("FAIL dual_busy got %h want 0c", bus.busy_mask); end
    step();
    checks++; if (bus.Reg_Write !== 1'b1 || bus.Reg_input_address !== 3'd3 || bus.Reg_input_data !== 16'h5555) begin errors++; $display("FAIL dual_first got %b %h %h want 1 3 5555", bus.Reg_Write, bus.Reg_input_address, bus.Reg_input_data); end
    checks++; if (bus.pending_count !== 4'd1) begin errors++; $display("FAIL dual_pending1 got %0d want 1", bus.pending_count); end
    step();
    checks++; if (bus.Reg_Write !== 1'b1 || bus.Reg_input_address !== 3'd2 || bus.Reg_input_data !== 16'hAAAA) begin errors++; $display("FAIL dual_second got %b %h %h want 1 2 aaaa", bus.Reg_Write, bus.Reg_input_address, bus.Reg_input_data); end
    step();
    checks++; if (bus.Reg_Write !== 1'b0 || bus.pending_count !== 4'd0) begin errors++; $display("FAIL dual_done got %b %0d want 0 0", bus.Reg_Write, bus.pending_count); end
  endtask

  task automatic test_back_to_back();
    wb_entry_t exp_q[$];
    wb_entry_t head;
    logic      popped, exp_mem_rdy, exp_alu_rdy;
    int        accepted, seen;
    accepted = 0;
    seen     = 0;
    for (int i = 0; i < 10; i++) begin
      bus.mem_valid = (i < 6);
      bus.alu_valid = (i < 6);
      bus.mem_addr  = 3'(2 * i);
      bus.mem_data  = 16'hB000 + 16'(i);
      bus.alu_addr  = 3'(2 * i + 1);
      bus.alu_data  = 16'hA000 + 16'(i);
      #1;
      exp_mem_rdy = (exp_q.size() < 4);
      exp_alu_rdy = (exp_q.size() <= 2);
      if (i < 6) begin
        checks++; if (bus.mem_ready !== exp_mem_rdy || bus.alu_ready !== exp_alu_rdy) begin errors++; $display("FAIL b2b_ready[%0d] got %b%b want %b%b", i, bus.mem_ready, bus.alu_ready, exp_mem_rdy, exp_alu_rdy); end
      end
      popped = (exp_q.size() > 0);
      if (popped) head = exp_q.pop_front();
      if (i < 6 && exp_mem_rdy) begin exp_q.push_back('{addr: bus.mem_addr, data: bus.mem_data}); accepted++; end
      if (i < 6 && exp_alu_rdy) begin exp_q.push_back('{addr: bus.alu_addr, data: bus.alu_data}); accepted++; end
      step();
      if (bus.Reg_Write === 1'b1) seen++;
      checks++; if (bus.Reg_Write !== popped) begin errors++; $display("FAIL b2b_wr[%0d] got %b want %b", i, bus.Reg_Write, popped); end
      if (popped) begin
        checks++; if (bus.Reg_input_address !== head.addr || bus.Reg_input_data !== head.data) begin errors++; $display("FAIL b2b_order[%0d] got %h %h want %h %h", i, bus.Reg_input_address, bus.Reg_input_data, head.addr, head.data); end
      end
      checks++; if (bus.pending_count !== 4'(exp_q.size())) begin errors++; $display("FAIL b2b_pending[%0d] got %0d want %0d", i, bus.pending_count, exp_q.size()); end
    end
    idle_inputs();
    checks++; if (seen !== accepted) begin errors++; $display("FAIL b2b_count got %0d want %0d", seen, accepted); end
    step();
  endtask

  task automatic test_forward();
    bus.fwd_addr  = 3'd5;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 3'd5;
    bus.mem_data  = 16'h1111;
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 3'd5;
    bus.alu_data  = 16'h2222;
    #1;
    checks++; if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 16'h0) begin errors++; $display("FAIL fwd_empty got %b %h want 0 0000", bus.fwd_hit, bus.fwd_data); end
    step();
    idle_inputs();
    checks++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 16'h2222) begin errors++; $display("FAIL fwd_both_q got %b %h want 1 2222", bus.fwd_hit, bus.fwd_data); end
    checks++; if (bus.busy_mask !== 8'h20) begin errors++; $display("FAIL fwd_busy got %h want 20", bus.busy_mask); end
    step();
    checks++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 16'h2222) begin errors++; $display("FAIL fwd_out_and_q got %b %h want 1 2222", bus.fwd_hit, bus.fwd_data); end
    bus.fwd_addr = 3'd4;
    #1;
    checks++; if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 16'h0) begin errors++; $display("FAIL fwd_other got %b %h want 0 0000", bus.fwd_hit, bus.fwd_data); end
    bus.fwd_addr = 3'd5;
    step();
    checks++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 16'h2222) begin errors++; $display("FAIL fwd_out_last got %b %h want 1 2222", bus.fwd_hit, bus.fwd_data); end
    step();
    checks++; if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 16'h0) begin errors++; $display("FAIL fwd_clear got %b %h want 0 0000", bus.fwd_hit, bus.fwd_data); end
  endtask

  task automatic test_reset_midflight();
    bus.fwd_addr  = 3'd2;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 3'd1;
    bus.mem_data  = 16'h0101;
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 3'd2;
    bus.alu_data  = 16'h0202;
    step();
    bus.mem_valid = 1'b0;
    bus.alu_addr  = 3'd3;
    bus.alu_data  = 16'h0303;
    step();
    idle_inputs();
    checks++; if (bus.Reg_Write !== 1'b1 || bus.pending_count !== 4'd2) begin errors++; $display("FAIL midrst_pre got %b %0d want 1 2", bus.Reg_Write, bus.pending_count); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.Reg_Write !== 1'b0) begin errors++; $display("FAIL midrst_wr got %b want 0", bus.Reg_Write); end
    checks++; if (bus.busy_mask !== 8'h00 || bus.pending_count !== 4'd0) begin errors++; $display("FAIL midrst_state got %h %0d want 00 0", bus.busy_mask, bus.pending_count); end
    checks++; if (bus.fwd_hit !== 1'b0) begin errors++; $display("FAIL midrst_fwd got %b want 0", bus.fwd_hit); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.Reg_Write !== 1'b0 || bus.pending_count !== 4'd0) begin errors++; $display("FAIL midrst_after[%0d] got %b %0d want 0 0", i, bus.Reg_Write, bus.pending_count); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_alu();
    test_dual_accept();
    test_back_to_back();
    test_forward();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
